// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access-size codes, command record,
// lock-ownership state and the alignment check.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;

  typedef enum logic {
    OWN_NONE = 1'b0,
    OWN_HELD = 1'b1
  } own_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [2:0]             funct3;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   id;
    logic                   err;
  } mem_cmd_t;

  // Illegal size codes count as misaligned so they never reach the memory.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      BYTE, BYTE_U: return 1'b0;
      HALF, HALF_U: return a[0];
      WORD:         return (a != 2'b00);
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_lock_arb2.sv
// Two-way round-robin arbiter with a bounded lock: a locking winner keeps the
// grant for at most MAX_LOCK consecutive cycles.
module rr_lock_arb2
  import dmem_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  own_state_e      r_state, w_state_next;
  logic            r_ptr, w_ptr_next;
  logic            r_owner, w_owner_next;
  logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
  logic            w_any, w_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= OWN_NONE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = OWN_NONE;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    w_cnt_next   = '0;
    w_any        = |i_req;
    if (r_state == OWN_HELD && i_req[r_owner]) w_win = r_owner;
    else if (i_req[r_ptr])                     w_win = r_ptr;
    else                                       w_win = ~r_ptr;
    o_gnt = w_any ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    // A fresh lock starts the streak at one; a held lock extends it.
    w_cnt_inc = (r_state == OWN_HELD && r_owner == w_win) ? r_cnt + CW'(1) : CW'(1);
    if (w_any) begin
      w_ptr_next = ~w_win;
      if (i_lock[w_win] && w_cnt_inc < CW'(MAX_LOCK)) begin
        w_state_next = OWN_HELD;
        w_owner_next = w_win;
        w_cnt_next   = w_cnt_inc;
      end
    end
  end

  assign o_gnt_id = w_win;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the LSU (requester 0) and DMA (requester 1).
// Optional perf counters are enabled with DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRESS_SIZE = DMEM_ADDR_W,
  parameter int N            = DMEM_DATA_W,
  parameter int MAX_LOCK     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req,
  input  logic [1:0]                lock,
  input  logic [1:0]                we,
  input  logic [5:0]                funct3,
  input  logic [2*ADDRESS_SIZE-1:0] addr,
  input  logic [2*N-1:0]            wdata,
  output logic [1:0]                gnt,
  output logic [1:0]                rvalid,
  output logic [N-1:0]              rdata,
  output logic                      err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [2:0]                mem_word_control,
  output logic [ADDRESS_SIZE-1:0]   mem_rd_addr,
  output logic [ADDRESS_SIZE-1:0]   mem_wr_addr,
  output logic [N-1:0]              mem_wdata,
  input  logic [N-1:0]              mem_rdata
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]               grant_cnt0,
  output logic [31:0]               grant_cnt1,
  output logic [31:0]               conflict_cnt
`endif
);

  logic [1:0]              w_gnt;
  logic                    w_gnt_id;
  logic [ADDRESS_SIZE-1:0] w_sel_addr;
  mem_cmd_t                w_cmd_next, r_cmd;
  logic [1:0]              r_rvalid;
  logic                    r_err;
  logic [N-1:0]            r_rdata;

  rr_lock_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_req    (req),
    .i_lock   (lock),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign gnt = rst ? w_gnt : 2'b00;
  assign w_sel_addr = w_gnt_id ? addr[2*ADDRESS_SIZE-1:ADDRESS_SIZE] : addr[ADDRESS_SIZE-1:0];

  always_comb begin
    w_cmd_next = '0;
    if (|w_gnt) begin
      w_cmd_next.valid  = 1'b1;
      w_cmd_next.we     = we[w_gnt_id];
      w_cmd_next.funct3 = w_gnt_id ? funct3[5:3] : funct3[2:0];
      w_cmd_next.addr   = w_sel_addr;
      w_cmd_next.wdata  = w_gnt_id ? wdata[2*N-1:N] : wdata[N-1:0];
      w_cmd_next.id     = w_gnt_id;
      w_cmd_next.err    = is_misaligned(w_cmd_next.funct3, w_sel_addr[1:0]);
    end
  end

  // A misaligned command still flows down the pipe to produce its error
  // response, but never strobes the memory.
  assign mem_read         = r_cmd.valid & ~r_cmd.err & ~r_cmd.we;
  assign mem_write        = r_cmd.valid & ~r_cmd.err &  r_cmd.we;
  assign mem_word_control = r_cmd.funct3;
  assign mem_rd_addr      = r_cmd.addr;
  assign mem_wr_addr      = r_cmd.addr;
  assign mem_wdata        = r_cmd.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd    <= '0;
      r_rvalid <= 2'b00;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_cmd    <= w_cmd_next;
      r_rvalid <= r_cmd.valid ? (r_cmd.id ? 2'b10 : 2'b01) : 2'b00;
      r_err    <= r_cmd.valid & r_cmd.err;
      if (mem_read) r_rdata <= mem_rdata;
    end
  end

  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rdata  = r_rdata;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] r_grant_cnt0, r_grant_cnt1, r_conflict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_cnt0   <= '0;
      r_grant_cnt1   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt[0] && r_grant_cnt0 != '1) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (w_gnt[1] && r_grant_cnt1 != '1) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      if ((&req) && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign grant_cnt0   = r_grant_cnt0;
  assign grant_cnt1   = r_grant_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
